board_writer: RTL and testbench

Writes a landed tetromino into the board RAM, then detects and removes full rows by shifting the rows above them down. It sits between the top-level game control FSM and the `ram_board` write port. It is the write-side counterpart of the collision path, which only reads the board. Control pulses `start` when a collision freezes the falling piece, and waits for `done` before spawning the next piece.

---
 rtl/tetris_pkg.sv | 48 ++++
 rtl/board_writer_if.sv | 31 +++
 rtl/tetromino_cells.sv | 64 ++++++
 rtl/board_writer.sv | 191 +++++++++++++++++++
 tb/tb_board_writer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tetris_pkg
// Purpose  : Shared piece codes, colours, board defaults and writer states.
// Revision : 1.0
// ============================================================================
package tetris_pkg;

    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 20;

    localparam logic [5:0] EMPTY_CELL = 6'd0;

    localparam logic [2:0] PIECE_I = 3'd0;
    localparam logic [2:0] PIECE_O = 3'd1;
    localparam logic [2:0] PIECE_T = 3'd2;
    localparam logic [2:0] PIECE_S = 3'd3;
    localparam logic [2:0] PIECE_Z = 3'd4;
    localparam logic [2:0] PIECE_J = 3'd5;
    localparam logic [2:0] PIECE_L = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_SCAN_RD   = 3'd2,
        ST_SCAN_CHK  = 3'd3,
        ST_SHIFT_RD  = 3'd4,
        ST_SHIFT_WR  = 3'd5,
        ST_CLEAR_TOP = 3'd6,
        ST_DONE      = 3'd7
    } bw_state_t;

    // Every colour is nonzero so a placed cell never reads back as empty.
    function automatic logic [5:0] piece_colour(input logic [2:0] piece);
        case (piece)
            PIECE_I: return 6'h0F;
            PIECE_O: return 6'h3C;
            PIECE_T: return 6'h22;
            PIECE_S: return 6'h0C;
            PIECE_Z: return 6'h30;
            PIECE_J: return 6'h03;
            PIECE_L: return 6'h34;
            default: return 6'h3F;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_writer_if.sv
`default_nettype none
// ============================================================================
// Interface : board_writer_if
// Purpose   : Control request/response and board RAM port of the writer.
// Revision  : 1.0
// ============================================================================
interface board_writer_if;
    logic       start;
    logic [2:0] piece;
    logic [1:0] rotation;
    logic [4:0] anc_X;
    logic [5:0] anc_Y;
    logic [5:0] ram_rdata;
    logic [7:0] ram_addr;
    logic [5:0] ram_wdata;
    logic       ram_wren;
    logic       busy;
    logic       done;
    logic [2:0] lines_cleared;

    modport slave (
        input  start, piece, rotation, anc_X, anc_Y, ram_rdata,
        output ram_addr, ram_wdata, ram_wren, busy, done, lines_cleared
    );

    modport master (
        output start, piece, rotation, anc_X, anc_Y, ram_rdata,
        input  ram_addr, ram_wdata, ram_wren, busy, done, lines_cleared
    );
endinterface
`default_nettype wire

// File: rtl/tetromino_cells.sv
`default_nettype none
// ============================================================================
// Module   : tetromino_cells
// Purpose  : Combinational (piece, rotation, k) -> (dx, dy) in a 4x4 box.
// Revision : 1.0
// ============================================================================
module tetromino_cells
    import tetris_pkg::*;
(
    input  wire logic [2:0] piece,
    input  wire logic [1:0] rotation,
    input  wire logic [1:0] k,
    output logic      [1:0] dx,
    output logic      [1:0] dy
);

    // Each shape packs four {dx,dy} nibbles, cell k=0 in the top nibble.
    logic [15:0] w_shape;
    logic [3:0]  w_cell;

    always_comb begin
        w_shape = 16'h0415;
        case (piece)
            PIECE_I: w_shape = rotation[0] ? 16'h0123 : 16'h048C;
            PIECE_O: w_shape = 16'h0415;
            PIECE_T: case (rotation)
                2'd0:    w_shape = 16'h0485;
                2'd1:    w_shape = 16'h4156;
                2'd2:    w_shape = 16'h4159;
                default: w_shape = 16'h0152;
            endcase
            PIECE_S: w_shape = rotation[0] ? 16'h0156 : 16'h4815;
            PIECE_Z: w_shape = rotation[0] ? 16'h4152 : 16'h0459;
            PIECE_J: case (rotation)
                2'd0:    w_shape = 16'h0159;
                2'd1:    w_shape = 16'h0412;
                2'd2:    w_shape = 16'h0489;
                default: w_shape = 16'h4526;
            endcase
            PIECE_L: case (rotation)
                2'd0:    w_shape = 16'h8159;
                2'd1:    w_shape = 16'h0126;
                2'd2:    w_shape = 16'h0481;
                default: w_shape = 16'h0456;
            endcase
            default: w_shape = 16'h0415;
        endcase
    end

    always_comb begin
        w_cell = w_shape[15:12];
        case (k)
            2'd0:    w_cell = w_shape[15:12];
            2'd1:    w_cell = w_shape[11:8];
            2'd2:    w_cell = w_shape[7:4];
            default: w_cell = w_shape[3:0];
        endcase
    end

    assign dx = w_cell[3:2];
    assign dy = w_cell[1:0];

endmodule
`default_nettype wire

// File: rtl/board_writer.sv
`default_nettype none
// ============================================================================
// Module   : board_writer
// Purpose  : Stamps a landed piece into board RAM, then removes full rows.
// Revision : 1.0
// ============================================================================
module board_writer
    import tetris_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    board_writer_if.slave   bus
);

    localparam logic [7:0] W8       = 8'(BOARD_W);
    localparam logic [7:0] H8       = 8'(BOARD_H);
    localparam logic [7:0] LAST_COL = 8'(BOARD_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(BOARD_H - 1);

    bw_state_t   state_q, state_d;
    logic [2:0]  piece_q, piece_d;
    logic [1:0]  rot_q, rot_d;
    logic [4:0]  anc_x_q, anc_x_d;
    logic [5:0]  anc_y_q, anc_y_d;
    logic [1:0]  k_q, k_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  c_q, c_d;
    logic [7:0]  s_q, s_d;
    logic [2:0]  lines_q, lines_d;

    logic [1:0]  w_dx, w_dy;
    logic [7:0]  w_cell_x, w_cell_y;
    logic        w_in_range;
    logic [7:0]  w_addr;
    logic [5:0]  w_wdata;
    logic        w_wren;

    function automatic logic [7:0] addr_of(input logic [7:0] row, input logic [7:0] col);
        return row * W8 + col;
    endfunction

    tetromino_cells u_cells (
        .piece    (piece_q),
        .rotation (rot_q),
        .k        (k_q),
        .dx       (w_dx),
        .dy       (w_dy)
    );

    assign w_cell_x   = {3'b000, anc_x_q} + {6'b000000, w_dx};
    assign w_cell_y   = {2'b00, anc_y_q} + {6'b000000, w_dy};
    assign w_in_range = (w_cell_x < W8) && (w_cell_y < H8);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            piece_q <= 3'd0;
            rot_q   <= 2'd0;
            anc_x_q <= 5'd0;
            anc_y_q <= 6'd0;
            k_q     <= 2'd0;
            r_q     <= 8'd0;
            c_q     <= 8'd0;
            s_q     <= 8'd0;
            lines_q <= 3'd0;
        end else begin
            state_q <= state_d;
            piece_q <= piece_d;
            rot_q   <= rot_d;
            anc_x_q <= anc_x_d;
            anc_y_q <= anc_y_d;
            k_q     <= k_d;
            r_q     <= r_d;
            c_q     <= c_d;
            s_q     <= s_d;
            lines_q <= lines_d;
        end
    end

    always_comb begin
        state_d = state_q;
        piece_d = piece_q;
        rot_d   = rot_q;
        anc_x_d = anc_x_q;
        anc_y_d = anc_y_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        s_d     = s_q;
        lines_d = lines_q;
        w_addr  = 8'd0;
        w_wdata = EMPTY_CELL;
        w_wren  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    piece_d = bus.piece;
                    rot_d   = bus.rotation;
                    anc_x_d = bus.anc_X;
                    anc_y_d = bus.anc_Y;
                    k_d     = 2'd0;
                    lines_d = 3'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_addr  = addr_of(w_cell_y, w_cell_x);
                w_wdata = piece_colour(piece_q);
                w_wren  = w_in_range;
                k_d     = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    r_d     = LAST_ROW;
                    c_d     = 8'd0;
                    state_d = ST_SCAN_RD;
                end
            end
            ST_SCAN_RD: begin
                w_addr  = addr_of(r_q, c_q);
                state_d = ST_SCAN_CHK;
            end
            ST_SCAN_CHK: begin
                if (bus.ram_rdata == EMPTY_CELL) begin
                    if (r_q == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = r_q - 8'd1;
                        c_d     = 8'd0;
                        state_d = ST_SCAN_RD;
                    end
                end else if (c_q < LAST_COL) begin
                    c_d     = c_q + 8'd1;
                    state_d = ST_SCAN_RD;
                end else begin
                    lines_d = (lines_q == 3'd7) ? lines_q : lines_q + 3'd1;
                    s_d     = r_q;
                    c_d     = 8'd0;
                    // A full top row has nothing above it to pull down.
                    state_d = (r_q == 8'd0) ? ST_CLEAR_TOP : ST_SHIFT_RD;
                end
            end
            ST_SHIFT_RD: begin
                w_addr  = addr_of(s_q - 8'd1, c_q);
                state_d = ST_SHIFT_WR;
            end
            ST_SHIFT_WR: begin
                w_addr  = addr_of(s_q, c_q);
                w_wdata = bus.ram_rdata;
                w_wren  = 1'b1;
                state_d = ST_SHIFT_RD;
                if (c_q < LAST_COL) begin
                    c_d = c_q + 8'd1;
                end else if (s_q > 8'd1) begin
                    s_d = s_q - 8'd1;
                    c_d = 8'd0;
                end else begin
                    c_d     = 8'd0;
                    state_d = ST_CLEAR_TOP;
                end
            end
            ST_CLEAR_TOP: begin
                w_addr  = c_q;
                w_wdata = EMPTY_CELL;
                w_wren  = 1'b1;
                if (c_q < LAST_COL) begin
                    c_d = c_q + 8'd1;
                end else begin
                    // Rescan the same row: the row shifted into it may be full too.
                    c_d     = 8'd0;
                    state_d = ST_SCAN_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ram_addr      = w_addr;
    assign bus.ram_wdata     = w_wdata;
    assign bus.ram_wren      = w_wren;
    assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.lines_cleared = lines_q;

endmodule
`default_nettype wire

// File: tb/tb_board_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_writer
// Purpose  : Randomized and directed checks of board_writer against a board model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_board_writer;

    localparam int W     = 10;
    localparam int H     = 20;
    localparam int N     = W * H;
    localparam int LIMIT = 5000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    board_writer_if bus ();

    board_writer #(.BOARD_W(W), .BOARD_H(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [5:0] mem      [0:N-1];
    logic [5:0] load_img [0:N-1];
    logic       load_req = 1'b0;

    always_ff @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= load_img[i];
        end else if (bus.ram_wren && int'(bus.ram_addr) < N) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= (int'(bus.ram_addr) < N) ? mem[bus.ram_addr] : 6'd0;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference shapes as 4x4 occupancy bitmaps, bit index = y*4 + x.
    function automatic logic [15:0] ref_mask(input int p, input int r);
        case (p)
            0: return (r % 2 == 0) ? 16'h000F : 16'h1111;
            1: return 16'h0033;
            2: case (r) 0: return 16'h0027; 1: return 16'h0232; 2: return 16'h0072; default: return 16'h0131; endcase
            3: return (r % 2 == 0) ? 16'h0036 : 16'h0231;
            4: return (r % 2 == 0) ? 16'h0063 : 16'h0132;
            5: case (r) 0: return 16'h0071; 1: return 16'h0113; 2: return 16'h0047; default: return 16'h0322; endcase
            default: case (r) 0: return 16'h0074; 1: return 16'h0311; 2: return 16'h0017; default: return 16'h0223; endcase
        endcase
    endfunction

    function automatic int ref_colour(input int p);
        case (p)
            0: return 'h0F; 1: return 'h3C; 2: return 'h22; 3: return 'h0C;
            4: return 'h30; 5: return 'h03; default: return 'h34;
        endcase
    endfunction

    int cur_img [0:N-1];
    int exp_img [0:N-1];
    int exp_lines, exp_cycles, exp_wr_piece, exp_wr_all;

    // Place the piece, then repeatedly remove the lowest full row while
    // accounting for the cycles each scan, shift and clear costs.
    task automatic model_op(input int p, input int r, input int ax, input int ay);
        logic [15:0] m;
        int row, first_empty;
        bit fin;
        for (int i = 0; i < N; i++) exp_img[i] = cur_img[i];
        m = ref_mask(p, r);
        exp_wr_piece = 0;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) begin
                if (ax + b % 4 < W && ay + b / 4 < H) begin
                    exp_img[(ay + b / 4) * W + ax + b % 4] = ref_colour(p);
                    exp_wr_piece++;
                end
            end
        end
        exp_wr_all = exp_wr_piece;
        exp_lines  = 0;
        exp_cycles = 6;
        row = H - 1;
        fin = 1'b0;
        while (!fin) begin
            first_empty = W;
            for (int c = W - 1; c >= 0; c--) if (exp_img[row * W + c] == 0) first_empty = c;
            if (first_empty < W) begin
                exp_cycles += 2 * (first_empty + 1);
                if (row == 0) fin = 1'b1;
                else row--;
            end else begin
                exp_cycles += 2 * W + 2 * W * row + W;
                exp_wr_all += W * row + W;
                if (exp_lines < 7) exp_lines++;
                for (int rr = row; rr > 0; rr--)
                    for (int c = 0; c < W; c++) exp_img[rr * W + c] = exp_img[(rr - 1) * W + c];
                for (int c = 0; c < W; c++) exp_img[c] = 0;
            end
        end
    endtask

    task automatic load_board();
        @(negedge clk);
        for (int i = 0; i < N; i++) load_img[i] = 6'(cur_img[i]);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_op(input string tag, input int p, input int r,
                          input int ax, input int ay, input bit poke);
        int cyc, wr_all, wr_piece, diffs;
        load_board();
        model_op(p, r, ax, ay);
        bus.piece    = 3'(p);
        bus.rotation = 2'(r);
        bus.anc_X    = 5'(ax);
        bus.anc_Y    = 6'(ay);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        wr_all = 0;
        wr_piece = 0;
        check_val({tag, "_busy"}, int'(bus.busy), 1);
        while (!bus.done && cyc < LIMIT) begin
            if (bus.ram_wren) begin
                wr_all++;
                if (cyc <= 4) wr_piece++;
            end
            if (poke && cyc == 3) begin
                bus.start    = 1'b1;
                bus.piece    = 3'((p + 1) % 7);
                bus.rotation = 2'(r + 1);
                bus.anc_X    = 5'd0;
                bus.anc_Y    = 6'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check_val({tag, "_latency"}, cyc + 1, exp_cycles);
        check_val({tag, "_lines"}, int'(bus.lines_cleared), exp_lines);
        check_val({tag, "_busy_at_done"}, int'(bus.busy), 0);
        check_val({tag, "_piece_writes"}, wr_piece, exp_wr_piece);
        check_val({tag, "_all_writes"}, wr_all, exp_wr_all);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, int'(bus.done), 0);
        check_val({tag, "_lines_hold"}, int'(bus.lines_cleared), exp_lines);
        diffs = 0;
        for (int i = 0; i < N; i++) if (int'(mem[i]) != exp_img[i]) diffs++;
        check_val({tag, "_board_diffs"}, diffs, 0);
        if (cyc >= LIMIT) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_addr"},  int'(bus.ram_addr), 0);
        check_val({tag, "_wdata"}, int'(bus.ram_wdata), 0);
        check_val({tag, "_wren"},  int'(bus.ram_wren), 0);
        check_val({tag, "_busy"},  int'(bus.busy), 0);
        check_val({tag, "_done"},  int'(bus.done), 0);
        check_val({tag, "_lines"}, int'(bus.lines_cleared), 0);
    endtask

    task automatic clear_cur();
        for (int i = 0; i < N; i++) cur_img[i] = 0;
    endtask

    task automatic setup_two_rows();
        clear_cur();
        for (int c = 0; c < 8; c++) begin
            cur_img[18 * W + c] = 'h15;
            cur_img[19 * W + c] = 'h2B;
        end
    endtask

    task automatic setup_one_row();
        clear_cur();
        for (int c = 0; c < 6; c++) cur_img[19 * W + c] = 'h11;
        cur_img[18 * W + 3] = 'h2A;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.piece    = 3'd0;
        bus.rotation = 2'd0;
        bus.anc_X    = 5'd0;
        bus.anc_Y    = 6'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // O on an empty board: every row scanned, one cell each.
        clear_cur();
        run_op("o_empty", 1, 0, 4, 18, 1'b0);
        check_val("o_empty_addr184", int'(mem[184]), 'h3C);
        check_val("o_empty_addr195", int'(mem[195]), 'h3C);

        // I completes row 19; row 18 content drops into it.
        setup_one_row();
        run_op("i_one_row", 0, 0, 6, 19, 1'b0);
        check_val("i_one_row_cell193", int'(mem[193]), 'h2A);
        check_val("i_one_row_cell190", int'(mem[190]), 0);

        // O completes two rows at once.
        setup_two_rows();
        run_op("o_two_rows", 1, 0, 8, 18, 1'b0);

        // I hanging off the right edge: only two cells land.
        clear_cur();
        run_op("i_edge", 0, 0, 8, 5, 1'b0);
        check_val("i_edge_addr58", int'(mem[58]), 'h0F);

        // A start pulse while busy must be ignored.
        setup_one_row();
        run_op("poke", 0, 0, 6, 19, 1'b1);

        // Reset in the middle of the first shift pass.
        setup_two_rows();
        load_board();
        bus.piece    = 3'd1;
        bus.rotation = 2'd0;
        bus.anc_X    = 5'd8;
        bus.anc_Y    = 6'd18;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        check_val("pre_reset_lines", int'(bus.lines_cleared), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        setup_one_row();
        run_op("after_reset", 0, 0, 6, 19, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int nrows, p, r, ax, ay;
            bit full;
            clear_cur();
            nrows = int'($urandom_range(0, 4));
            for (int rr = H - nrows; rr < H; rr++) begin
                full = ($urandom_range(0, 7) == 0);
                for (int c = 0; c < W; c++)
                    cur_img[rr * W + c] = (full || $urandom_range(0, 7) != 0) ? int'($urandom_range(1, 63)) : 0;
            end
            p  = int'($urandom_range(0, 6));
            r  = int'($urandom_range(0, 3));
            ax = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 31)) : int'($urandom_range(0, 9));
            ay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 63)) : int'($urandom_range(14, 19));
            run_op($sformatf("rnd%0d", t), p, r, ax, ay, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
